// File: rtl/scan_pkg.sv
// Shared constants, state encoding and scan-order helper for the display scan receiver.
package scan_pkg;

    localparam int unsigned NDIG = 6;
    localparam int unsigned DW   = 4;
    localparam int unsigned IW   = $clog2(NDIG);

    typedef enum logic {
        SYNC    = 1'b0,
        CAPTURE = 1'b1
    } state_e;

    // Digit 0 is strobed on the MSB, so the code walks right as the index grows.
    function automatic logic [NDIG-1:0] exp_code(input logic [IW-1:0] idx);
        logic [NDIG-1:0] msb;
        msb = {1'b1, {(NDIG-1){1'b0}}};
        return msb >> idx;
    endfunction

endpackage

// File: rtl/onehot_idx.sv
// Combinational decode of the digit strobe into scan index, idle and multi-hot flags.
module onehot_idx
    import scan_pkg::*;
(
    input  logic [NDIG-1:0] dig_sel,
    output logic [IW-1:0]   index,
    output logic            idle,
    output logic            multi
);

    always_comb begin
        index = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (dig_sel == exp_code(IW'(k))) begin
                index = IW'(k);
            end
        end
    end

    assign idle  = (dig_sel == '0);
    assign multi = ($countones(dig_sel) > 1);

endmodule

// File: rtl/scan_capture.sv
// Rebuilds 6-digit frames from the multiplexed display scan and publishes them atomically
// together with a frame count and sticky protocol error flags.
module scan_capture
    import scan_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NDIG-1:0]      dig_sel,
    input  logic [DW-1:0]        dig_data,
    input  logic                 err_clr,
    output logic [NDIG*DW-1:0]   digits,
    output logic                 frame_valid,
    output logic [7:0]           frame_cnt,
    output logic                 seq_err,
    output logic                 onehot_err,
    output logic                 locked
);

    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    state_e                   state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    // Element NDIG-1-d holds digit d so the packed vector has digit 0 on top.
    logic [NDIG-1:0][DW-1:0]  shadow_q, shadow_d;
    logic [NDIG-1:0][DW-1:0]  digits_q, digits_d;
    logic                     fv_q, fv_d;
    logic [7:0]               cnt_q, cnt_d;
    logic                     seq_q, seq_d;
    logic                     oh_q, oh_d;

    logic [IW-1:0]            code;
    logic                     idle;
    logic                     multi;

    onehot_idx u_decode (
        .dig_sel (dig_sel),
        .index   (code),
        .idle    (idle),
        .multi   (multi)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        digits_d = digits_q;
        fv_d     = 1'b0;
        cnt_d    = cnt_q;
        // A new error in the same cycle overrides the clear below.
        seq_d    = seq_q & ~err_clr;
        oh_d     = oh_q & ~err_clr;

        unique case (state_q)
            SYNC: begin
                if (multi) begin
                    oh_d = 1'b1;
                end else if (!idle && code == '0) begin
                    shadow_d[NDIG-1] = dig_data;
                    idx_d            = IW'(1);
                    state_d          = CAPTURE;
                end
            end
            CAPTURE: begin
                if (idle) begin
                    // gaps are legal; hold
                end else if (multi) begin
                    oh_d    = 1'b1;
                    state_d = SYNC;
                    idx_d   = '0;
                end else if (code == idx_q) begin
                    shadow_d[LAST - idx_q] = dig_data;
                    if (idx_q == LAST) begin
                        digits_d = shadow_d;
                        fv_d     = 1'b1;
                        cnt_d    = cnt_q + 8'd1;
                        idx_d    = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else if (code == '0) begin
                    seq_d            = 1'b1;
                    shadow_d[NDIG-1] = dig_data;
                    idx_d            = IW'(1);
                end else begin
                    seq_d   = 1'b1;
                    state_d = SYNC;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = SYNC;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SYNC;
            idx_q    <= '0;
            shadow_q <= '0;
            digits_q <= '0;
            fv_q     <= 1'b0;
            cnt_q    <= '0;
            seq_q    <= 1'b0;
            oh_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            digits_q <= digits_d;
            fv_q     <= fv_d;
            cnt_q    <= cnt_d;
            seq_q    <= seq_d;
            oh_q     <= oh_d;
        end
    end

    assign digits      = digits_q;
    assign frame_valid = fv_q;
    assign frame_cnt   = cnt_q;
    assign seq_err     = seq_q;
    assign onehot_err  = oh_q;
    assign locked      = (state_q == CAPTURE);

endmodule

// File: tb/tb_scan_capture.sv
// Self-checking bench for scan_capture: directed scenarios plus a randomized run against a model.
module tb_scan_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  dig_sel = '0;
    logic [3:0]  dig_data = '0;
    logic        err_clr = 1'b0;
    logic [23:0] digits;
    logic        frame_valid;
    logic [7:0]  frame_cnt;
    logic        seq_err;
    logic        onehot_err;
    logic        locked;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    bit fv_at_last;

    // Reference model state: digit values by digit number, expected next digit.
    logic [3:0]  m_sh [6];
    logic [23:0] m_digits;
    int          m_cnt, m_next;
    bit          m_fv, m_seq, m_oh, m_lock;

    always #5 clk = ~clk;

    scan_capture dut (
        .clk         (clk),
        .rst         (rst),
        .dig_sel     (dig_sel),
        .dig_data    (dig_data),
        .err_clr     (err_clr),
        .digits      (digits),
        .frame_valid (frame_valid),
        .frame_cnt   (frame_cnt),
        .seq_err     (seq_err),
        .onehot_err  (onehot_err),
        .locked      (locked)
    );

    task automatic step(input logic [5:0] sel, input logic [3:0] data, input bit clr,
                        input bit r);
        int n, k;
        dig_sel  = sel;
        dig_data = data;
        err_clr  = clr;
        rst      = r;
        @(posedge clk);
        n = $countones(sel);
        k = 0;
        for (int p = 0; p < 6; p++) if (sel[p]) k = 5 - p;
        m_fv = 1'b0;
        if (r) begin
            m_digits = '0; m_cnt = 0; m_next = 0;
            m_seq = 1'b0; m_oh = 1'b0; m_lock = 1'b0;
            for (int i = 0; i < 6; i++) m_sh[i] = '0;
        end else begin
            if (clr) begin m_seq = 1'b0; m_oh = 1'b0; end
            if (n > 1) begin
                m_oh = 1'b1; m_lock = 1'b0; m_next = 0;
            end else if (n == 1) begin
                if (!m_lock) begin
                    if (k == 0) begin m_sh[0] = data; m_next = 1; m_lock = 1'b1; end
                end else if (k == m_next) begin
                    m_sh[k] = data;
                    if (k == 5) begin
                        m_digits = '0;
                        for (int i = 0; i < 6; i++) m_digits = {m_digits[19:0], m_sh[i]};
                        m_fv = 1'b1;
                        m_cnt = (m_cnt + 1) % 256;
                        m_next = 0;
                    end else begin
                        m_next++;
                    end
                end else if (k == 0) begin
                    m_seq = 1'b1; m_sh[0] = data; m_next = 1;
                end else begin
                    m_seq = 1'b1; m_lock = 1'b0; m_next = 0;
                end
            end
        end
        #1;
        if (frame_valid) pulses++;
    endtask

    task automatic do_reset();
        step(6'b0, 4'h0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(6'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic digit(input int d, input logic [3:0] data);
        logic [5:0] msb;
        msb = 6'b100000;
        step(msb >> d, data, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [23:0] v, input int gap);
        for (int d = 0; d < 6; d++) begin
            idle(gap);
            digit(d, v[(5 - d) * 4 +: 4]);
        end
        fv_at_last = frame_valid;
    endtask

    task automatic test_reset();
        step(6'b100000, 4'h7, 1'b0, 1'b1);
        do_reset();
        n_checks++; if (digits !== 24'h0) begin n_fail++;
            $display("FAIL reset_digits: got %h want 000000", digits); end
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_fv: got %b want 0", frame_valid); end
        n_checks++; if (frame_cnt !== 8'd0) begin n_fail++;
            $display("FAIL reset_cnt: got %0d want 0", frame_cnt); end
        n_checks++; if ({seq_err, onehot_err, locked} !== 3'b000) begin n_fail++;
            $display("FAIL reset_flags: got %b want 000", {seq_err, onehot_err, locked}); end
    endtask

    task automatic test_clean();
        do_reset();
        pulses = 0;
        send_frame(24'h123456, 0);
        n_checks++; if (digits !== 24'h123456) begin n_fail++;
            $display("FAIL clean_digits: got %h want 123456", digits); end
        n_checks++; if (frame_cnt !== 8'd1 || locked !== 1'b1) begin n_fail++;
            $display("FAIL clean_cnt_lock: got cnt=%0d lock=%b want 1/1", frame_cnt, locked); end
        n_checks++; if ({seq_err, onehot_err} !== 2'b00) begin n_fail++;
            $display("FAIL clean_err: got %b want 00", {seq_err, onehot_err}); end
        idle(1);
        n_checks++; if (pulses !== 1 || frame_valid !== 1'b0) begin n_fail++;
            $display("FAIL clean_pulse: got pulses=%0d fv=%b want 1/0", pulses, frame_valid); end
    endtask

    task automatic test_mid_scan();
        do_reset();
        digit(3, 4'h1); digit(4, 4'h2); digit(5, 4'h3); idle(1);
        n_checks++; if (locked !== 1'b0 || frame_cnt !== 8'd0) begin n_fail++;
            $display("FAIL midscan_ignore: got lock=%b cnt=%0d want 0/0", locked, frame_cnt); end
        send_frame(24'h987654, 0);
        n_checks++; if (digits !== 24'h987654 || frame_cnt !== 8'd1 || seq_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midscan_frame: got %h cnt=%0d seq=%b want 987654/1/0",
                     digits, frame_cnt, seq_err); end
    endtask

    task automatic test_gaps();
        do_reset();
        pulses = 0;
        send_frame(24'h123456, 3);
        n_checks++; if (fv_at_last !== 1'b1 || pulses !== 1) begin n_fail++;
            $display("FAIL gaps_timing: got fv=%b pulses=%0d want 1/1", fv_at_last, pulses); end
        n_checks++; if (digits !== 24'h123456 || {seq_err, onehot_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL gaps_frame: got %h err=%b want 123456/00",
                     digits, {seq_err, onehot_err}); end
    endtask

    task automatic test_order_fault();
        do_reset();
        send_frame(24'h123456, 0);
        digit(0, 4'h9); digit(1, 4'h9); digit(3, 4'h9);
        n_checks++; if (seq_err !== 1'b1 || locked !== 1'b0 || digits !== 24'h123456) begin
            n_fail++;
            $display("FAIL order_fault: got seq=%b lock=%b dig=%h want 1/0/123456",
                     seq_err, locked, digits); end
        send_frame(24'h654321, 0);
        n_checks++; if (digits !== 24'h654321 || frame_cnt !== 8'd2) begin n_fail++;
            $display("FAIL order_recover: got %h cnt=%0d want 654321/2", digits, frame_cnt); end
        step(6'b0, 4'h0, 1'b1, 1'b0);
        n_checks++; if (seq_err !== 1'b0 || digits !== 24'h654321) begin n_fail++;
            $display("FAIL order_clr: got seq=%b dig=%h want 0/654321", seq_err, digits); end
    endtask

    task automatic test_multi();
        do_reset();
        pulses = 0;
        digit(0, 4'h1); digit(1, 4'h2);
        step(6'b110000, 4'h3, 1'b0, 1'b0);
        n_checks++; if (onehot_err !== 1'b1 || locked !== 1'b0) begin n_fail++;
            $display("FAIL multi_flag: got oh=%b lock=%b want 1/0", onehot_err, locked); end
        digit(2, 4'h3); digit(3, 4'h4); digit(4, 4'h5); digit(5, 4'h6); idle(1);
        n_checks++; if (pulses !== 0 || frame_cnt !== 8'd0 || digits !== 24'h0) begin n_fail++;
            $display("FAIL multi_nopub: got pulses=%0d cnt=%0d dig=%h want 0/0/0",
                     pulses, frame_cnt, digits); end
        // Multi-hot together with err_clr: set wins.
        step(6'b000011, 4'h0, 1'b1, 1'b0);
        n_checks++; if (onehot_err !== 1'b1) begin n_fail++;
            $display("FAIL multi_setwins: got %b want 1", onehot_err); end
    endtask

    task automatic test_restart();
        do_reset();
        digit(0, 4'h7); digit(1, 4'h7); digit(2, 4'h7);
        send_frame(24'h314159, 0);
        n_checks++; if (seq_err !== 1'b1 || digits !== 24'h314159 || frame_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL restart: got seq=%b dig=%h cnt=%0d want 1/314159/1",
                     seq_err, digits, frame_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_frame(24'h111111, 0);
        pulses = 0;
        digit(0, 4'h2); digit(1, 4'h2); digit(2, 4'h2);
        do_reset();
        n_checks++; if ({digits, frame_cnt, locked} !== 33'h0) begin n_fail++;
            $display("FAIL rstmid_zero: got dig=%h cnt=%0d lock=%b want 0", digits, frame_cnt,
                     locked); end
        digit(3, 4'h2); digit(4, 4'h2); digit(5, 4'h2); idle(1);
        n_checks++; if (pulses !== 0 || digits !== 24'h0 || frame_cnt !== 8'd0) begin n_fail++;
            $display("FAIL rstmid_nopub: got pulses=%0d dig=%h cnt=%0d want 0/0/0",
                     pulses, digits, frame_cnt); end
    endtask

    task automatic test_wrap();
        logic [23:0] v;
        do_reset();
        pulses = 0;
        for (int f = 0; f < 256; f++) begin
            v = 24'($urandom);
            send_frame(v, 0);
            if (f == 254) begin
                n_checks++; if (frame_cnt !== 8'd255) begin n_fail++;
                    $display("FAIL wrap_255: got %0d want 255", frame_cnt); end
            end
        end
        n_checks++; if (frame_cnt !== 8'd0 || pulses !== 256 || digits !== v) begin n_fail++;
            $display("FAIL wrap_0: got cnt=%0d pulses=%0d dig=%h want 0/256/%h",
                     frame_cnt, pulses, digits, v); end
    endtask

    task automatic test_random();
        int r, gk;
        logic [5:0] sel, msb;
        bit clr, rr;
        msb = 6'b100000;
        gk = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r   = int'($urandom_range(99));
            rr  = (r == 0);
            clr = ($urandom_range(15) == 0);
            if (r < 60) begin
                sel = msb >> gk;
                gk = (gk + 1) % 6;
            end else if (r < 75) begin
                sel = '0;
            end else if (r < 88) begin
                sel = 6'b000001 << $urandom_range(5);
            end else begin
                sel = 6'($urandom);
            end
            step(sel, 4'($urandom), clr, rr);
            n_checks++;
            if ({digits, frame_valid, frame_cnt, seq_err, onehot_err, locked} !==
                {m_digits, m_fv, 8'(m_cnt), m_seq, m_oh, m_lock}) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got dig=%h fv=%b cnt=%0d seq=%b oh=%b lock=%b want dig=%h fv=%b cnt=%0d seq=%b oh=%b lock=%b",
                         c, digits, frame_valid, frame_cnt, seq_err, onehot_err, locked,
                         m_digits, m_fv, m_cnt, m_seq, m_oh, m_lock);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_mid_scan();
        test_gaps();
        test_order_fault();
        test_multi();
        test_restart();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
